// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types, constants and window check for the RAM host arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int unsigned c_NUM_HOSTS = 2;

    typedef enum logic [0:0] {
        HOST_IFETCH = 1'b0,
        HOST_LSU    = 1'b1
    } host_id_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } host_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } host_rsp_t;

    typedef struct packed {
        logic     valid;
        host_id_e host;
        logic     is_read;
        logic     err;
    } rsp_tag_t;

    // 33-bit compare so a window touching the top of the address space cannot wrap.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned depth);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = lo + (33'(depth) << 2);
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_rr
// Brief    : Two-way round-robin arbiter with last-grant pointer.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [c_NUM_HOSTS-1:0] req,
    output logic [c_NUM_HOSTS-1:0] gnt
);

    host_id_e r_last;

    // Reset suppresses grants so requests held during reset are never accepted.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_last == HOST_LSU) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= HOST_LSU;
        end else if (|gnt) begin
            r_last <= host_id_e'(gnt[1]);
        end
    end

endmodule : ram_arb_rr
`default_nettype wire

// File: rtl/ram_host_arb.sv
`default_nettype none
// ============================================================================
// Module   : ram_host_arb
// Brief    : Two-host req/gnt/rvalid front end onto one RAM port, with range check.
// Revision : 1.0 - initial release
// ============================================================================
module ram_host_arb
    import ram_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR           = 32'h0010_0000,
    parameter int unsigned DEPTH               = 128,
    parameter int unsigned WIDTH               = 32,
    parameter bit          ERR_ON_OUT_OF_RANGE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             h0_req_i,
    input  logic             h0_we_i,
    input  logic [3:0]       h0_be_i,
    input  logic [31:0]      h0_addr_i,
    input  logic [WIDTH-1:0] h0_wdata_i,
    output logic             h0_gnt_o,
    output logic             h0_rvalid_o,
    output logic [WIDTH-1:0] h0_rdata_o,
    output logic             h0_err_o,
    input  logic             h1_req_i,
    input  logic             h1_we_i,
    input  logic [3:0]       h1_be_i,
    input  logic [31:0]      h1_addr_i,
    input  logic [WIDTH-1:0] h1_wdata_i,
    output logic             h1_gnt_o,
    output logic             h1_rvalid_o,
    output logic [WIDTH-1:0] h1_rdata_o,
    output logic             h1_err_o,
    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [3:0]       ram_be_o,
    output logic [31:0]      ram_addr_o,
    output logic [WIDTH-1:0] ram_wdata_o,
    input  logic             ram_rvalid_i,
    input  logic [WIDTH-1:0] ram_rdata_i
);

    // Window offset mask: keeps word bits only, wrapping modulo the window size.
    localparam logic [31:0] c_OFFS_MASK = 32'(DEPTH * 4 - 1) & ~32'h3;

    host_req_t              w_h0_req;
    host_req_t              w_h1_req;
    host_req_t              w_win;
    logic [c_NUM_HOSTS-1:0] w_gnt;
    host_id_e               w_sel;
    logic                   w_any;
    logic                   w_err;
    logic                   w_ram_req;
    logic                   w_read_ok;
    rsp_tag_t               r_tag;
    host_rsp_t              w_rsp [c_NUM_HOSTS];

    assign w_h0_req = '{we: h0_we_i, be: h0_be_i, addr: h0_addr_i, wdata: h0_wdata_i};
    assign w_h1_req = '{we: h1_we_i, be: h1_be_i, addr: h1_addr_i, wdata: h1_wdata_i};

    ram_arb_rr u_rr (
        .clk (clk_i),
        .rst (rst_i),
        .req ({h1_req_i, h0_req_i}),
        .gnt (w_gnt)
    );

    assign h0_gnt_o  = w_gnt[0];
    assign h1_gnt_o  = w_gnt[1];
    assign w_any     = |w_gnt;
    assign w_sel     = host_id_e'(w_gnt[1]);
    assign w_win     = (w_sel == HOST_LSU) ? w_h1_req : w_h0_req;
    assign w_err     = ERR_ON_OUT_OF_RANGE && !in_window(w_win.addr, BASE_ADDR, DEPTH);
    assign w_ram_req = w_any && !w_err;

    always_comb begin
        ram_req_o   = w_ram_req;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (w_ram_req) begin
            ram_we_o    = w_win.we;
            ram_be_o    = w_win.be;
            ram_addr_o  = (w_win.addr - BASE_ADDR) & c_OFFS_MASK;
            ram_wdata_o = w_win.wdata;
        end
    end

    // One tag per grant; every grant yields exactly one response next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tag <= '0;
        end else if (w_any) begin
            r_tag <= '{valid: 1'b1, host: w_sel, is_read: ~w_win.we, err: w_err};
        end else begin
            r_tag <= '0;
        end
    end

    assign w_read_ok = r_tag.valid && r_tag.is_read && !r_tag.err;

    for (genvar h = 0; h < c_NUM_HOSTS; h++) begin : g_rsp
        assign w_rsp[h] = (!rst_i && r_tag.valid && (r_tag.host == host_id_e'(h)))
                        ? '{rvalid: 1'b1, rdata: (w_read_ok ? ram_rdata_i : '0), err: r_tag.err}
                        : '0;
    end

    assign h0_rvalid_o = w_rsp[0].rvalid;
    assign h0_rdata_o  = w_rsp[0].rdata;
    assign h0_err_o    = w_rsp[0].err;
    assign h1_rvalid_o = w_rsp[1].rvalid;
    assign h1_rdata_o  = w_rsp[1].rdata;
    assign h1_err_o    = w_rsp[1].err;

    // RAM read-valid must agree with the locally tracked pending read.
    ram_rvalid_consistent_a : assert property (@(posedge clk_i) disable iff (rst_i)
        ram_rvalid_i == w_read_ok);

endmodule : ram_host_arb
`default_nettype wire

// File: tb/tb_ram_host_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_host_arb
// Brief    : Scoreboard bench for ram_host_arb with a host-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_host_arb;

    localparam logic [31:0] c_BASE  = 32'h0010_0000;
    localparam int          c_DEPTH = 128;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic h0_req, h0_we, h0_gnt, h0_rvalid, h0_err;
    logic h1_req, h1_we, h1_gnt, h1_rvalid, h1_err;
    logic [3:0]  h0_be, h1_be, ram_be;
    logic [31:0] h0_addr, h0_wdata, h0_rdata, h1_addr, h1_wdata, h1_rdata;
    logic ram_req, ram_we, ram_rvalid;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    // Second instance with wrapping windows, driven only by directed stimulus.
    logic wh1_req, wh1_we;
    logic [31:0] wh1_addr;
    logic w0_gnt, w0_rvalid, w0_err, w1_gnt, w1_rvalid, w1_err;
    logic [31:0] w0_rdata, w1_rdata;
    logic wr_req, wr_we, wr_rvalid;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr, wr_wdata, wr_rdata;

    logic [31:0] mem       [c_DEPTH];
    logic [31:0] model_mem [c_DEPTH];
    int          model_last;
    exp_t        scb_q [2][$];
    int          cyc = 0;
    int          vectors = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_host_arb u_dut (
        .clk_i(clk), .rst_i(rst),
        .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr),
        .h0_wdata_i(h0_wdata), .h0_gnt_o(h0_gnt), .h0_rvalid_o(h0_rvalid),
        .h0_rdata_o(h0_rdata), .h0_err_o(h0_err),
        .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr),
        .h1_wdata_i(h1_wdata), .h1_gnt_o(h1_gnt), .h1_rvalid_o(h1_rvalid),
        .h1_rdata_o(h1_rdata), .h1_err_o(h1_err),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
    );

    ram_host_arb #(.ERR_ON_OUT_OF_RANGE(1'b0)) u_dut_wrap (
        .clk_i(clk), .rst_i(rst),
        .h0_req_i(1'b0), .h0_we_i(1'b0), .h0_be_i(4'h0), .h0_addr_i(32'h0),
        .h0_wdata_i(32'h0), .h0_gnt_o(w0_gnt), .h0_rvalid_o(w0_rvalid),
        .h0_rdata_o(w0_rdata), .h0_err_o(w0_err),
        .h1_req_i(wh1_req), .h1_we_i(wh1_we), .h1_be_i(4'hF), .h1_addr_i(wh1_addr),
        .h1_wdata_i(32'h0), .h1_gnt_o(w1_gnt), .h1_rvalid_o(w1_rvalid),
        .h1_rdata_o(w1_rdata), .h1_err_o(w1_err),
        .ram_req_o(wr_req), .ram_we_o(wr_we), .ram_be_o(wr_be), .ram_addr_o(wr_addr),
        .ram_wdata_o(wr_wdata), .ram_rvalid_i(wr_rvalid), .ram_rdata_i(wr_rdata)
    );

    // Environment RAM: one-cycle read latency, junk on the data bus otherwise.
    always @(posedge clk) begin
        ram_rvalid <= ram_req & ~ram_we;
        ram_rdata  <= $urandom;
        if (ram_req) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[8:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[8:2]];
            end
        end
    end

    always @(posedge clk) begin
        wr_rvalid <= wr_req & ~wr_we;
        wr_rdata  <= wr_addr ^ 32'hA5A5_0000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: grant rule, window rule and memory contents at host level.
    always @(negedge clk) begin
        logic [1:0]  exp_g;
        int          h;
        logic        we;
        logic [3:0]  be;
        logic [31:0] a, wd;
        longint unsigned la;
        int          word;
        exp_t        e;
        if (rst)                  exp_g = 2'b00;
        else if (h0_req && h1_req) exp_g = (model_last == 1) ? 2'b01 : 2'b10;
        else                      exp_g = {h1_req, h0_req};
        chk("grant", {30'b0, h1_gnt, h0_gnt}, {30'b0, exp_g});
        if (rst) begin
            model_last = 1;
            scb_q[0].delete();
            scb_q[1].delete();
            chk("ram_req_in_reset", 32'(ram_req), 32'd0);
        end else if (exp_g != 2'b00) begin
            h  = exp_g[1] ? 1 : 0;
            we = h ? h1_we : h0_we;
            be = h ? h1_be : h0_be;
            a  = h ? h1_addr : h0_addr;
            wd = h ? h1_wdata : h0_wdata;
            la = 64'(a);
            e.due = cyc + 1;
            if (la >= 64'(c_BASE) && la < 64'(c_BASE) + 64'(4 * c_DEPTH)) begin
                word = int'((a - c_BASE) >> 2);
                chk("ram_req", 32'(ram_req), 32'd1);
                chk("ram_addr", ram_addr, 32'(word * 4));
                chk("ram_we_be", {27'b0, ram_we, ram_be}, {27'b0, we, be});
                if (we) chk("ram_wdata", ram_wdata, wd);
                e.err = 1'b0;
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model_mem[word][8*b +: 8] = wd[8*b +: 8];
                    e.rdata = 32'h0;
                end else begin
                    e.rdata = model_mem[word];
                end
            end else begin
                chk("ram_req_oor", 32'(ram_req), 32'd0);
                chk("ram_bus_oor", ram_addr | ram_wdata | {27'b0, ram_we, ram_be}, 32'd0);
                e.rdata = 32'h0;
                e.err   = 1'b1;
            end
            scb_q[h].push_back(e);
            model_last = h;
        end else begin
            chk("ram_idle", ram_addr | ram_wdata | {26'b0, ram_req, ram_we, ram_be}, 32'd0);
        end
    end

    // Monitor: pops expected responses whenever a host response is presented.
    always @(negedge clk) begin
        logic [1:0]  rv, er;
        logic [31:0] rd [2];
        exp_t        e;
        rv = {h1_rvalid, h0_rvalid};
        er = {h1_err, h0_err};
        rd[0] = h0_rdata;
        rd[1] = h1_rdata;
        for (int h = 0; h < 2; h++) begin
            if (rst) begin
                chk($sformatf("h%0d_rvalid_in_reset", h), 32'(rv[h]), 32'd0);
            end else if (rv[h]) begin
                if (scb_q[h].size() == 0) begin
                    chk($sformatf("h%0d_unexpected_rvalid", h), 32'(rv[h]), 32'd0);
                end else begin
                    e = scb_q[h].pop_front();
                    chk($sformatf("h%0d_latency", h), 32'(cyc), 32'(e.due));
                    chk($sformatf("h%0d_rdata", h), rd[h], e.rdata);
                    chk($sformatf("h%0d_err", h), 32'(er[h]), 32'(e.err));
                end
            end else if (scb_q[h].size() != 0 && scb_q[h][0].due <= cyc) begin
                chk($sformatf("h%0d_missing_rvalid", h), 32'(rv[h]), 32'd1);
                scb_q[h].delete(0);
            end
            if (!rv[h]) chk($sformatf("h%0d_idle_rsp", h), rd[h] | 32'(er[h]), 32'd0);
        end
    end

    task automatic set_host(input int h, input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd);
        if (h == 0) begin
            h0_req = req; h0_we = we; h0_be = be; h0_addr = addr; h0_wdata = wd;
        end else begin
            h1_req = req; h1_we = we; h1_be = be; h1_addr = addr; h1_wdata = wd;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel = $urandom_range(0, 9);
        if (sel <= 6)      return c_BASE + $urandom_range(0, 4 * c_DEPTH - 1);
        else if (sel == 7) return c_BASE + 4 * c_DEPTH + $urandom_range(0, 15);
        else if (sel == 8) return c_BASE - $urandom_range(1, 8);
        else               return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFC : $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          cnt;
        rst = 1'b1;
        set_host(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_host(1, 0, 0, 4'h0, 32'h0, 32'h0);
        wh1_req = 1'b0; wh1_we = 1'b0; wh1_addr = 32'h0;
        model_last = 1;
        for (int i = 0; i < c_DEPTH; i++) begin
            v = $urandom;
            mem[i] = v;
            model_mem[i] = v;
        end
        mem[2] = 32'hDEAD_BEEF;
        model_mem[2] = 32'hDEAD_BEEF;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {25'b0, h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, h0_err, h1_err, ram_req},
            32'd0);
        chk("reset_rdata", h0_rdata | h1_rdata, 32'd0);

        // Single read of RAM word 2.
        step();
        set_host(0, 1, 0, 4'hF, 32'h0010_0008, 32'h0);
        @(negedge clk);
        chk("tp1_h0_gnt", 32'(h0_gnt), 32'd1);
        chk("tp1_ram_addr", ram_addr, 32'h8);
        step();
        set_host(0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("tp1_h0_rdata", h0_rdata, 32'hDEAD_BEEF);
        chk("tp1_h1_rvalid", 32'(h1_rvalid), 32'd0);

        // Back-to-back contention: no bubbles on the RAM port.
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            set_host(0, 1, 0, 4'hF, c_BASE + 4 * $urandom_range(0, c_DEPTH - 1), 32'h0);
            set_host(1, 1, 0, 4'hF, c_BASE + 4 * $urandom_range(0, c_DEPTH - 1), 32'h0);
            @(negedge clk);
            cnt += int'(ram_req);
        end
        chk("b2b_ram_req_count", 32'(cnt), 32'd6);

        // Partial write then read-back.
        step();
        set_host(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_host(1, 1, 1, 4'b0011, 32'h0010_0010, 32'h1234_5678);
        step();
        set_host(1, 0, 0, 4'h0, 32'h0, 32'h0);
        set_host(0, 1, 0, 4'hF, 32'h0010_0010, 32'h0);
        @(negedge clk);
        chk("tp3_h1_write_rsp", h1_rdata | 32'(h1_err) | 32'(!h1_rvalid), 32'd0);
        step();
        set_host(0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        v = h0_rdata & 32'h0000_FFFF;
        chk("tp3_low_half", v, 32'h0000_5678);

        // One past the window.
        step();
        set_host(1, 1, 0, 4'hF, 32'h0010_0200, 32'h0);
        @(negedge clk);
        chk("tp4_ram_req", 32'(ram_req), 32'd0);
        step();
        set_host(1, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("tp4_h1_err", {31'b0, h1_err}, 32'd1);

        // Wrapping instance.
        step();
        wh1_req = 1'b1; wh1_addr = 32'h0010_0200;
        @(negedge clk);
        chk("wrap_gnt", 32'(w1_gnt), 32'd1);
        chk("wrap_ram_req", 32'(wr_req), 32'd1);
        chk("wrap_ram_addr", wr_addr, 32'h0);
        step();
        wh1_addr = 32'h000F_FFFC;
        @(negedge clk);
        chk("wrap_rsp0", {w1_rdata[31:1], w1_err ^ w1_rvalid}, 32'hA5A5_0001);
        chk("wrap_ram_addr_low", wr_addr, 32'h1FC);
        step();
        wh1_req = 1'b0;
        @(negedge clk);
        chk("wrap_rsp1", w1_rdata, 32'hA5A5_01FC);
        chk("wrap_err", {30'b0, w1_err, w1_rvalid}, 32'd1);

        // Reset right after a read grant; first post-reset tie goes to host 0.
        step();
        set_host(0, 1, 0, 4'hF, 32'h0010_0004, 32'h0);
        step();
        rst = 1'b1;
        set_host(1, 1, 0, 4'hF, 32'h0010_0040, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_tie", {30'b0, h1_gnt, h0_gnt}, 32'd1);
        chk("post_reset_no_rvalid", 32'(h0_rvalid), 32'd0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step();
            rst = ($urandom_range(0, 99) == 0);
            for (int h = 0; h < 2; h++)
                set_host(h, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                         4'($urandom), rand_addr(), $urandom);
        end
        step();
        rst = 1'b0;
        set_host(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_host(1, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (3) step();
        @(negedge clk);
        chk("scoreboard_drained", 32'(scb_q[0].size() + scb_q[1].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_ram_host_arb
`default_nettype wire
